stopwatch_lap_ctrl: RTL and testbench

- Control and display-select stage around the msec/sec/min up/down counter chain.
- Turns debounced button levels into start/stop/clear/lap actions and drives the chain's run enable and synchronous clear.
- Stores up to DEPTH lap times and feeds the three bcd_decoder instances with either the live count, a frozen split, or a stored lap.

---
 rtl/stopwatch_lap_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Start/stop/clear/lap control for the stopwatch counter chain, with lap storage
// and selection of what the BCD display stage shows (live, frozen split, or a stored lap).
module stopwatch_lap_ctrl #(
    parameter int W          = 8,
    parameter int DEPTH      = 4,
    parameter int HOLD_TICKS = 200
) (
    input  logic         CLOCK_50_div,
    input  logic         debouncer_rst,
    input  logic         start_stop,
    input  logic         lap,
    input  logic         clear,
    input  logic [W-1:0] count_min,
    input  logic [W-1:0] count_sec,
    input  logic [W-1:0] count_msec,
    output logic         run,
    output logic         clr,
    output logic [W-1:0] disp_min,
    output logic [W-1:0] disp_sec,
    output logic [W-1:0] disp_msec,
    output logic [2:0]   lap_count,
    output logic         lap_full,
    output logic [1:0]   state
);

    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STOP   = 2'd2;
    localparam logic [1:0] REVIEW = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [2:0]     lapCount_q, lapCount_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           clr_q, clr_d;
    logic           lapFull_q;
    logic [2:0]     prev_q;
    logic [3*W-1:0] dispWord_q, dispWord_d;
    logic [3*W-1:0] lapMem_q [0:(1<<PW)-1];

    logic [2:0]     buttons;
    logic [2:0]     edges;
    logic           clearEdge, startEdge, lapEdge;
    logic           capture;
    logic [3*W-1:0] liveWord;
    logic [PW-1:0]  lastIdx;

    assign buttons   = {clear, start_stop, lap};
    assign edges     = buttons & ~prev_q;
    assign clearEdge = edges[2];
    assign startEdge = edges[1];
    assign lapEdge   = edges[0];
    assign liveWord  = {count_min, count_sec, count_msec};
    assign lastIdx   = PW'(lapCount_q - 3'd1);

    // Next-state logic; the if/else order inside each state gives clear > start > lap.
    always_comb begin
        state_d    = state_q;
        lapCount_d = lapCount_q;
        rdPtr_d    = rdPtr_q;
        clr_d      = 1'b0;
        capture    = 1'b0;
        hold_d     = (hold_q != '0) ? hold_q - HW'(1) : '0;
        case (state_q)
            IDLE: begin
                if (startEdge) state_d = RUN;
            end
            RUN: begin
                if (startEdge) begin
                    state_d = STOP;
                end else if (lapEdge && (lapCount_q < 3'(DEPTH))) begin
                    capture    = 1'b1;
                    lapCount_d = lapCount_q + 3'd1;
                    hold_d     = HW'(HOLD_TICKS);
                end
            end
            STOP: begin
                if (clearEdge) begin
                    clr_d      = 1'b1;
                    lapCount_d = '0;
                    hold_d     = '0;
                    state_d    = IDLE;
                end else if (startEdge) begin
                    state_d = RUN;
                end else if (lapEdge && (lapCount_q != '0)) begin
                    rdPtr_d = '0;
                    state_d = REVIEW;
                end
            end
            default: begin
                if (clearEdge) begin
                    clr_d      = 1'b1;
                    lapCount_d = '0;
                    hold_d     = '0;
                    state_d    = IDLE;
                end else if (startEdge) begin
                    state_d = STOP;
                end else if (lapEdge) begin
                    if (3'(rdPtr_q) == lapCount_q - 3'd1) state_d = STOP;
                    else rdPtr_d = rdPtr_q + PW'(1);
                end
            end
        endcase
    end

    // Display source follows the next state so the view changes together with the action.
    always_comb begin
        dispWord_d = liveWord;
        if (state_d == REVIEW) begin
            dispWord_d = lapMem_q[rdPtr_d];
        end else if (hold_d != '0) begin
            dispWord_d = capture ? liveWord : lapMem_q[lastIdx];
        end
    end

    // Button history resets high: a button held through reset must be released before it counts.
    always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
        if (debouncer_rst) begin
            state_q    <= IDLE;
            lapCount_q <= '0;
            rdPtr_q    <= '0;
            hold_q     <= '0;
            clr_q      <= 1'b0;
            lapFull_q  <= 1'b0;
            prev_q     <= '1;
            dispWord_q <= '0;
        end else begin
            state_q    <= state_d;
            lapCount_q <= lapCount_d;
            rdPtr_q    <= rdPtr_d;
            hold_q     <= hold_d;
            clr_q      <= clr_d;
            lapFull_q  <= (lapCount_d == 3'(DEPTH));
            prev_q     <= buttons;
            dispWord_q <= dispWord_d;
        end
    end

    always_ff @(posedge CLOCK_50_div) begin
        if (capture) lapMem_q[lapCount_q[PW-1:0]] <= liveWord;
    end

    assign run       = (state_q == RUN);
    assign clr       = clr_q;
    assign state     = state_q;
    assign lap_count = lapCount_q;
    assign lap_full  = lapFull_q;
    assign disp_min  = dispWord_q[3*W-1:2*W];
    assign disp_sec  = dispWord_q[2*W-1:W];
    assign disp_msec = dispWord_q[W-1:0];

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed, scoreboard-driven bench for stopwatch_lap_ctrl.
module tb_stopwatch_lap_ctrl;

    localparam int W = 8;

    localparam int ID_STATE = 0;
    localparam int ID_RUN   = 1;
    localparam int ID_CLR   = 2;
    localparam int ID_DMIN  = 3;
    localparam int ID_DSEC  = 4;
    localparam int ID_DMSEC = 5;
    localparam int ID_LCNT  = 6;
    localparam int ID_LFULL = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         startStop, lapBtn, clearBtn;
    logic [W-1:0] cMin, cSec, cMsec;
    logic         run, clr, lapFull;
    logic [W-1:0] dMin, dSec, dMsec;
    logic [2:0]   lapCount;
    logic [1:0]   state;

    typedef struct {
        int          id;
        logic [31:0] val;
        string       tag;
    } expT;

    expT sbQ[$];
    int  compared   = 0;
    int  mismatched = 0;

    stopwatch_lap_ctrl #(.W(W), .DEPTH(4), .HOLD_TICKS(200)) dut (
        .CLOCK_50_div  (clk),
        .debouncer_rst (reset),
        .start_stop    (startStop),
        .lap           (lapBtn),
        .clear         (clearBtn),
        .count_min     (cMin),
        .count_sec     (cSec),
        .count_msec    (cMsec),
        .run           (run),
        .clr           (clr),
        .disp_min      (dMin),
        .disp_sec      (dSec),
        .disp_msec     (dMsec),
        .lap_count     (lapCount),
        .lap_full      (lapFull),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ss, input logic lp, input logic cl);
        startStop = ss;
        lapBtn    = lp;
        clearBtn  = cl;
    endtask

    task automatic setCounts(input int m, input int s, input int ms);
        cMin  = W'(m);
        cSec  = W'(s);
        cMsec = W'(ms);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input int id, input int val, input string tag);
        expT e;
        e.id  = id;
        e.val = 32'(val);
        e.tag = tag;
        sbQ.push_back(e);
    endtask

    task automatic expectAll(input int st, input int rn, input int cl, input int dm,
                             input int ds, input int dms, input int lc, input int lf);
        expectVal(ID_STATE, st,  "state");
        expectVal(ID_RUN,   rn,  "run");
        expectVal(ID_CLR,   cl,  "clr");
        expectVal(ID_DMIN,  dm,  "disp_min");
        expectVal(ID_DSEC,  ds,  "disp_sec");
        expectVal(ID_DMSEC, dms, "disp_msec");
        expectVal(ID_LCNT,  lc,  "lap_count");
        expectVal(ID_LFULL, lf,  "lap_full");
    endtask

    function automatic logic [31:0] observe(input int id);
        case (id)
            ID_STATE: return 32'(state);
            ID_RUN:   return 32'(run);
            ID_CLR:   return 32'(clr);
            ID_DMIN:  return 32'(dMin);
            ID_DSEC:  return 32'(dSec);
            ID_DMSEC: return 32'(dMsec);
            ID_LCNT:  return 32'(lapCount);
            default:  return 32'(lapFull);
        endcase
    endfunction

    task automatic checkOutput(input string step);
        expT         e;
        logic [31:0] obs;
        while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            obs = observe(e.id);
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s/%s observed=%0d expected=%0d", step, e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        int revMin [5];
        int revSec [5];
        int revMs  [5];
        int revSt  [5];
        revMin = '{0, 0, 0, 0, 0};
        revSec = '{12, 20, 21, 22, 50};
        revMs  = '{34, 1, 2, 3, 50};
        revSt  = '{3, 3, 3, 3, 2};

        // Reset state, with nonzero live counts to prove the display is cleared
        reset = 1'b1;
        applyStimulus(0, 0, 0);
        setCounts(5, 6, 7);
        repeat (2) @(posedge clk);
        #1;
        expectAll(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset");
        reset = 1'b0;
        tick();
        expectAll(0, 0, 0, 5, 6, 7, 0, 0);
        checkOutput("idleLive");

        // Lap and clear are ignored in IDLE
        applyStimulus(0, 1, 1);
        tick();
        expectAll(0, 0, 0, 5, 6, 7, 0, 0);
        checkOutput("idleIgnore");
        applyStimulus(0, 0, 0);
        tick();

        // Start, held for two cycles: one action only
        setCounts(0, 1, 2);
        applyStimulus(1, 0, 0);
        tick();
        expectAll(1, 1, 0, 0, 1, 2, 0, 0);
        checkOutput("start");
        setCounts(0, 1, 3);
        tick();
        expectAll(1, 1, 0, 0, 1, 3, 0, 0);
        checkOutput("startHeld");
        applyStimulus(0, 0, 0);
        tick();

        // Stop, then resume
        setCounts(0, 2, 0);
        applyStimulus(1, 0, 0);
        tick();
        expectAll(2, 0, 0, 0, 2, 0, 0, 0);
        checkOutput("stop");
        applyStimulus(0, 0, 0);
        tick();
        applyStimulus(1, 0, 0);
        tick();
        expectVal(ID_STATE, 1, "state");
        checkOutput("resume");
        applyStimulus(0, 0, 0);
        tick();

        // Lap at 00:12:34; split frozen for exactly 200 cycles
        setCounts(0, 12, 34);
        applyStimulus(0, 1, 0);
        tick();
        expectAll(1, 1, 0, 0, 12, 34, 1, 0);
        checkOutput("lap1");
        applyStimulus(0, 0, 0);
        for (int k = 1; k <= 200; k++) begin
            setCounts(0, 13, k);
            tick();
            if (k < 200) begin
                expectVal(ID_DMSEC, 34, "holdMsec");
                if (k == 199) begin
                    expectVal(ID_DMIN, 0, "holdMin");
                    expectVal(ID_DSEC, 12, "holdSec");
                end
            end else begin
                expectVal(ID_DMIN, 0, "liveMin");
                expectVal(ID_DSEC, 13, "liveSec");
                expectVal(ID_DMSEC, 200, "liveMsec");
            end
            checkOutput("hold");
        end

        // Three more laps fill storage; a fifth lap is ignored
        for (int i = 0; i < 3; i++) begin
            setCounts(0, 20 + i, i + 1);
            applyStimulus(0, 1, 0);
            tick();
            expectAll(1, 1, 0, 0, 20 + i, i + 1, i + 2, (i == 2) ? 1 : 0);
            checkOutput("lapFill");
            applyStimulus(0, 0, 0);
            tick();
        end
        setCounts(0, 30, 0);
        applyStimulus(0, 1, 0);
        tick();
        expectAll(1, 1, 0, 0, 22, 3, 4, 1);
        checkOutput("lapWhenFull");
        applyStimulus(0, 0, 0);
        tick();

        // Split persists across RUN->STOP, then expires to live
        applyStimulus(1, 0, 0);
        tick();
        expectAll(2, 0, 0, 0, 22, 3, 4, 1);
        checkOutput("stopFrozen");
        applyStimulus(0, 0, 0);
        repeat (200) tick();
        setCounts(0, 50, 50);
        tick();
        expectAll(2, 0, 0, 0, 50, 50, 4, 1);
        checkOutput("stopLive");

        // Review walks laps in order, then returns to STOP with live display
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0);
            tick();
            expectVal(ID_STATE, revSt[i], "revState");
            expectVal(ID_DMIN, revMin[i], "revMin");
            expectVal(ID_DSEC, revSec[i], "revSec");
            expectVal(ID_DMSEC, revMs[i], "revMsec");
            expectVal(ID_RUN, 0, "revRun");
            checkOutput("review");
            applyStimulus(0, 0, 0);
            tick();
            expectVal(ID_DMSEC, revMs[i], "revRelease");
            checkOutput("review");
        end

        // Start inside review goes to STOP without resuming
        applyStimulus(0, 1, 0);
        tick();
        expectVal(ID_STATE, 3, "state");
        checkOutput("reviewAgain");
        applyStimulus(0, 0, 0);
        tick();
        applyStimulus(1, 0, 0);
        tick();
        expectAll(2, 0, 0, 0, 50, 50, 4, 1);
        checkOutput("reviewStart");
        applyStimulus(0, 0, 0);
        tick();

        // Clear beats start in STOP
        applyStimulus(1, 0, 1);
        tick();
        expectAll(0, 0, 1, 0, 50, 50, 0, 0);
        checkOutput("clearWins");
        applyStimulus(0, 0, 0);
        tick();
        expectAll(0, 0, 0, 0, 50, 50, 0, 0);
        checkOutput("clrPulse");

        // Async reset during REVIEW with a hold still running
        applyStimulus(1, 0, 0);
        tick();
        applyStimulus(0, 0, 0);
        tick();
        setCounts(0, 40, 5);
        applyStimulus(0, 1, 0);
        tick();
        applyStimulus(0, 0, 0);
        tick();
        applyStimulus(1, 0, 0);
        tick();
        applyStimulus(0, 0, 0);
        tick();
        applyStimulus(0, 1, 0);
        tick();
        expectAll(3, 0, 0, 0, 40, 5, 1, 0);
        checkOutput("review2");
        applyStimulus(0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        expectAll(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resetReview");

        // Start held through reset release gives no action until re-pressed
        applyStimulus(1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        expectAll(0, 0, 0, 0, 40, 5, 0, 0);
        checkOutput("heldThroughReset");
        applyStimulus(0, 0, 0);
        tick();
        applyStimulus(1, 0, 0);
        tick();
        expectVal(ID_STATE, 1, "state");
        expectVal(ID_RUN, 1, "run");
        checkOutput("repress");
        applyStimulus(0, 0, 0);
        tick();

        // Async reset during an active hold
        setCounts(0, 41, 6);
        applyStimulus(0, 1, 0);
        tick();
        applyStimulus(0, 0, 0);
        setCounts(0, 42, 7);
        tick();
        expectAll(1, 1, 0, 0, 41, 6, 1, 0);
        checkOutput("holdBeforeReset");
        #3;
        reset = 1'b1;
        #1;
        expectAll(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resetHold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
